// File: rtl/io_port.sv
// Memory-mapped bidirectional byte I/O: eight tri-state port bytes, each with an output latch, plus a direction register.
// Optional build macro IO_PORT_SYNC_EN adds a 2-flop synchronizer on each pin byte ahead of the read mux.
module io_port #(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        addr,
  input  logic              RE,
  input  logic              WE,
  input  logic [DATA_W-1:0] Din,
  output logic [DATA_W-1:0] Dout,
  output logic              io_read,
  output logic              io_write,
  inout  wire  [DATA_W-1:0] IO0,
  inout  wire  [DATA_W-1:0] IO1,
  inout  wire  [DATA_W-1:0] IO2,
  inout  wire  [DATA_W-1:0] IO3,
  inout  wire  [DATA_W-1:0] IO4,
  inout  wire  [DATA_W-1:0] IO5,
  inout  wire  [DATA_W-1:0] IO6,
  inout  wire  [DATA_W-1:0] IO7,
  output logic [7:0]        io_ena
);

  localparam int NPORT = 8;

  logic [DATA_W-1:0] out_reg [NPORT];
  logic [NPORT-1:0]  dir;
  logic [DATA_W-1:0] pin_val [NPORT];
  logic [DATA_W-1:0] pin_rd  [NPORT];

  logic       in_win;
  logic       hit_port;
  logic       hit_dir;
  logic [3:0] off;
  logic [2:0] port_sel;

  // Pin drivers: a port drives its latch only while its direction bit is set.
  assign IO0 = dir[0] ? out_reg[0] : {DATA_W{1'bz}};
  assign IO1 = dir[1] ? out_reg[1] : {DATA_W{1'bz}};
  assign IO2 = dir[2] ? out_reg[2] : {DATA_W{1'bz}};
  assign IO3 = dir[3] ? out_reg[3] : {DATA_W{1'bz}};
  assign IO4 = dir[4] ? out_reg[4] : {DATA_W{1'bz}};
  assign IO5 = dir[5] ? out_reg[5] : {DATA_W{1'bz}};
  assign IO6 = dir[6] ? out_reg[6] : {DATA_W{1'bz}};
  assign IO7 = dir[7] ? out_reg[7] : {DATA_W{1'bz}};

  assign pin_val[0] = IO0;
  assign pin_val[1] = IO1;
  assign pin_val[2] = IO2;
  assign pin_val[3] = IO3;
  assign pin_val[4] = IO4;
  assign pin_val[5] = IO5;
  assign pin_val[6] = IO6;
  assign pin_val[7] = IO7;

  assign io_ena = dir;

  // Address decode: 16-byte window, offsets 9..15 are holes, nothing aliases.
  always_comb begin
    in_win   = (addr[7:4] == BASE_ADDR[7:4]);
    off      = addr[3:0];
    port_sel = addr[2:0];
    hit_port = in_win && !off[3];
    hit_dir  = in_win && (off == 4'd8);
  end

  assign io_read  = RE && (hit_port || hit_dir);
  assign io_write = WE && (hit_port || hit_dir);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NPORT; j++) out_reg[j] <= '0;
      dir <= '0;
    end else if (WE) begin
      if (hit_port) out_reg[port_sel] <= Din;
      if (hit_dir)  dir <= Din[NPORT-1:0];
    end
  end

`ifdef IO_PORT_SYNC_EN
  logic [DATA_W-1:0] pin_sync_p0 [NPORT];
  logic [DATA_W-1:0] pin_sync_p1 [NPORT];

  // Stage p0 -> p1: two flops per pin byte before the read mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NPORT; j++) begin
        pin_sync_p0[j] <= '0;
        pin_sync_p1[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NPORT; j++) begin
        pin_sync_p0[j] <= pin_val[j];
        pin_sync_p1[j] <= pin_sync_p0[j];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NPORT; j++) pin_rd[j] = pin_sync_p1[j];
  end
`else
  always_comb begin
    for (int j = 0; j < NPORT; j++) pin_rd[j] = pin_val[j];
  end
`endif

  // Read mux: the direction register read never goes through the synchronizer.
  always_comb begin
    Dout = '0;
    if (RE) begin
      if (hit_port)     Dout = pin_rd[port_sel];
      else if (hit_dir) Dout = {{(DATA_W-NPORT){1'b0}}, dir};
    end
  end

endmodule

// File: tb/tb_io_port.sv
// Bench for io_port: directed scenarios plus randomized bus traffic, checked against a behavioural register/pin model.
module tb_io_port;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr;
  logic       RE, WE;
  logic [7:0] Din;
  logic [7:0] Dout;
  logic       io_read, io_write;
  logic [7:0] io_ena;

  logic [7:0] ext_val [8];
  logic [7:0] ext_en;
  wire  [7:0] pin0, pin1, pin2, pin3, pin4, pin5, pin6, pin7;

  assign pin0 = ext_en[0] ? ext_val[0] : 8'bz;
  assign pin1 = ext_en[1] ? ext_val[1] : 8'bz;
  assign pin2 = ext_en[2] ? ext_val[2] : 8'bz;
  assign pin3 = ext_en[3] ? ext_val[3] : 8'bz;
  assign pin4 = ext_en[4] ? ext_val[4] : 8'bz;
  assign pin5 = ext_en[5] ? ext_val[5] : 8'bz;
  assign pin6 = ext_en[6] ? ext_val[6] : 8'bz;
  assign pin7 = ext_en[7] ? ext_val[7] : 8'bz;

  // Second instance with a relocated window; its pins are always externally driven.
  logic [7:0] hi_dout, hi_ena;
  logic       hi_read, hi_write;
  logic       hi_we = 1'b0;
  wire  [7:0] hp0, hp1, hp2, hp3, hp4, hp5, hp6, hp7;
  assign hp0 = 8'h30; assign hp1 = 8'h31; assign hp2 = 8'h32; assign hp3 = 8'h3C;
  assign hp4 = 8'h34; assign hp5 = 8'h35; assign hp6 = 8'h36; assign hp7 = 8'h37;

  always #5 clk = ~clk;

  io_port #(.BASE_ADDR(8'h00)) dut (
    .clk(clk), .rst(rst), .addr(addr), .RE(RE), .WE(WE), .Din(Din),
    .Dout(Dout), .io_read(io_read), .io_write(io_write),
    .IO0(pin0), .IO1(pin1), .IO2(pin2), .IO3(pin3),
    .IO4(pin4), .IO5(pin5), .IO6(pin6), .IO7(pin7),
    .io_ena(io_ena)
  );

  io_port #(.BASE_ADDR(8'h40)) dut_hi (
    .clk(clk), .rst(rst), .addr(addr), .RE(RE), .WE(hi_we), .Din(Din),
    .Dout(hi_dout), .io_read(hi_read), .io_write(hi_write),
    .IO0(hp0), .IO1(hp1), .IO2(hp2), .IO3(hp3),
    .IO4(hp4), .IO5(hp5), .IO6(hp6), .IO7(hp7),
    .io_ena(hi_ena)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: register contents plus two-deep pin history for the synchronized build.
  logic [7:0] m_out [8];
  logic [7:0] m_dir;
  logic [7:0] m_s0 [8];
  logic [7:0] m_s1 [8];

  function automatic logic [7:0] m_pin(input int j);
    return m_dir[j] ? m_out[j] : ext_val[j];
  endfunction

  function automatic bit m_mapped(input logic [7:0] a);
    int o;
    o = int'(a) - 0;
    return (o >= 0) && (o <= 8);
  endfunction

  function automatic logic [7:0] m_dout(input logic [7:0] a, input logic re);
    int o;
    o = int'(a);
    if (!re || !m_mapped(a)) return 8'h00;
    if (o == 8) return m_dir;
`ifdef IO_PORT_SYNC_EN
    return m_s1[o];
`else
    return m_pin(o);
`endif
  endfunction

  task automatic tick();
    if (rst) begin
      for (int j = 0; j < 8; j++) begin m_out[j] = 8'h00; m_s0[j] = 8'h00; m_s1[j] = 8'h00; end
      m_dir = 8'h00;
    end else begin
      for (int j = 0; j < 8; j++) begin m_s1[j] = m_s0[j]; m_s0[j] = m_pin(j); end
      if (WE && m_mapped(addr)) begin
        if (addr == 8'd8) m_dir = Din;
        else m_out[addr[2:0]] = Din;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus(input string tag);
    #1;
    chk({tag, ".dout"}, Dout, m_dout(addr, RE));
    chk({tag, ".rd"}, io_read, RE && m_mapped(addr));
    chk({tag, ".wr"}, io_write, WE && m_mapped(addr));
    chk({tag, ".ena"}, io_ena, m_dir);
  endtask

  // Writes DIR, releasing external drivers before the edge and re-enabling inputs after it.
  task automatic write_dir(input logic [7:0] v);
    addr = 8'd8; WE = 1'b1; RE = 1'b0; Din = v;
    ext_en = ~(m_dir | v);
    tick();
    WE = 1'b0;
    ext_en = ~m_dir;
  endtask

  task automatic settle();
`ifdef IO_PORT_SYNC_EN
    tick(); tick(); tick();
`else
    #1;
`endif
  endtask

  initial begin
    rst = 1'b1; addr = 8'h00; RE = 1'b0; WE = 1'b0; Din = 8'h00;
    for (int j = 0; j < 8; j++) ext_val[j] = 8'(j * j);
    ext_en = 8'hFF;
    for (int j = 0; j < 8; j++) begin m_out[j] = 8'hEE; m_s0[j] = 8'hEE; m_s1[j] = 8'hEE; end
    m_dir = 8'hEE;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    chk("reset.ena", io_ena, 8'h00);
    settle();

    // Read sweep with all pins externally driven.
    RE = 1'b1;
    for (int a = 0; a < 10; a++) begin
      addr = 8'(a);
      check_bus($sformatf("sweep_rd%0d", a));
    end
    RE = 1'b0;

    // Write A5 everywhere, one address per clock.
    WE = 1'b1; Din = 8'hA5;
    for (int a = 0; a < 10; a++) begin
      addr = 8'(a);
      if (a == 8) ext_en = ~8'hA5;
      check_bus($sformatf("sweep_wr%0d", a));
      tick();
    end
    WE = 1'b0;
    ext_en = ~m_dir;
    chk("wr.ena", io_ena, 8'hA5);
    #1;
    chk("wr.pin0", pin0, 8'hA5);
    chk("wr.pin2", pin2, 8'hA5);
    chk("wr.pin5", pin5, 8'hA5);
    chk("wr.pin7", pin7, 8'hA5);
    chk("wr.pin1_ext", pin1, 8'h01);
    settle();

    // Mixed readback: output ports read their latch, input ports read the outside.
    RE = 1'b1;
    addr = 8'd0; #1; chk("mix.p0", Dout, 8'hA5);
    addr = 8'd1; #1; chk("mix.p1", Dout, m_dout(addr, RE));
    addr = 8'd8; #1; chk("mix.dir", Dout, 8'hA5);
    RE = 1'b0;

    // Reset dominates: all ports become inputs again.
    write_dir(8'hFF);
    chk("all_out.ena", io_ena, 8'hFF);
    rst = 1'b1; WE = 1'b1; addr = 8'd8; Din = 8'hFF;
    tick();
    rst = 1'b0; WE = 1'b0;
    ext_en = 8'hFF;
    chk("rst.ena", io_ena, 8'h00);
    settle();
    RE = 1'b1; addr = 8'd3;
    check_bus("rst.rd3");
    RE = 1'b0;

    // Simultaneous read and write of DIR.
    write_dir(8'hA5);
    RE = 1'b1; WE = 1'b1; addr = 8'd8; Din = 8'h0F;
    ext_en = ~(8'hA5 | 8'h0F);
    #1;
    chk("rw.pre", Dout, 8'hA5);
    tick();
    WE = 1'b0;
    ext_en = ~m_dir;
    #1;
    chk("rw.post", Dout, 8'h0F);
    RE = 1'b0;

    // Relocated window on the second instance.
    settle();
    RE = 1'b1;
    addr = 8'h43; #1;
    chk("hi.43.dout", hi_dout, 8'h3C);
    chk("hi.43.rd", hi_read, 1'b1);
    addr = 8'h03; #1;
    chk("hi.03.dout", hi_dout, 8'h00);
    chk("hi.03.rd", hi_read, 1'b0);
    addr = 8'h50; #1;
    chk("hi.50.rd", hi_read, 1'b0);
    chk("hi.ena", hi_ena, 8'h00);
    RE = 1'b0;

    // Randomized traffic with DIR held at A5; DIR writes are kept out of this phase.
    write_dir(8'hA5);
    for (int i = 0; i < 400; i++) begin
      addr = 8'($urandom_range(0, 31));
      RE   = 1'($urandom_range(0, 1));
      WE   = 1'($urandom_range(0, 1));
      if (addr == 8'd8) WE = 1'b0;
      Din  = 8'($urandom);
      for (int j = 0; j < 8; j++) ext_val[j] = 8'($urandom);
      check_bus($sformatf("rnd%0d", i));
      tick();
    end
    RE = 1'b0; WE = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
